// File: rtl/reaction_stimulus.sv
// reaction_stimulus
// Stimulus side of the reaction-timer path. A rising edge on `trigger` starts
// a sequence that lights the ten start LEDs one at a time, every STEP_TICKS
// ticks. Once all ten are lit it holds for MIN_DELAY plus a pseudo-random
// number of ticks, then blanks the LEDs and pulses `start_counting` for one
// clock. A `response` press before that moment aborts the sequence and raises
// the sticky `false_start` flag instead of issuing the pulse.
//
// Parameters:
//   STEP_TICKS : ticks between successive LEDs lighting (1..65535)
//   MIN_DELAY  : minimum hold in ticks after all LEDs are lit (0..65408)
//
// Ports:
//   clk            : system clock, all logic on posedge
//   rst_n          : asynchronous active-low reset
//   tick           : one-cycle timebase enable (nominally 1 ms)
//   trigger        : user key level, rising edge arms a sequence
//   response       : user reaction key level (also the counter's end_counting)
//   lights[9:0]    : start-light LEDs, bit 0 lights first
//   start_counting : one-cycle pulse to the reaction counter at "go"
//   busy           : high while a sequence or hold is in progress
//   false_start    : sticky flag, response seen before go
//
// Build option:
//   REACTION_STIM_FIXED_DELAY_EN : when defined, the random part of the hold
//   is the constant 64 and the LFSR is not built (deterministic demo/bench).
module reaction_stimulus #(
  parameter int unsigned STEP_TICKS = 500,
  parameter int unsigned MIN_DELAY  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       trigger,
  input  logic       response,
  output logic [9:0] lights,
  output logic       start_counting,
  output logic       busy,
  output logic       false_start
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] STEP_LAST = 16'(STEP_TICKS - 1);
  localparam logic [15:0] MIN_HOLD  = 16'(MIN_DELAY);
  localparam logic [9:0]  ALL_LIT   = 10'h3FF;

  state_t      state_r, state_s;
  logic [15:0] step_r, step_s;
  logic [15:0] delay_r, delay_s;
  logic [9:0]  lights_r, lights_s;
  logic        start_r, start_s;
  logic        busy_r, busy_s;
  logic        fs_r, fs_s;
  logic        trigger_q_r;
  logic        rise_s;
  logic [9:0]  lights_shift_s;
  logic [6:0]  hold_rand_s;

`ifdef REACTION_STIM_FIXED_DELAY_EN
  assign hold_rand_s = 7'd64;
`else
  logic [6:0] lfsr_r;

  // x^7 + x^6 + 1, maximal length: all-zero state is never entered from 7'h01
  function automatic logic [6:0] lfsr_next(input logic [6:0] q);
    return {q[5:0], q[6] ^ q[5]};
  endfunction

  // Free-running LFSR supplying the random part of the hold time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 7'h01;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign hold_rand_s = lfsr_r;
`endif

  assign rise_s         = trigger & ~trigger_q_r;
  assign lights_shift_s = {lights_r[8:0], 1'b1};

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      step_r      <= 16'd0;
      delay_r     <= 16'd0;
      lights_r    <= 10'd0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      fs_r        <= 1'b0;
      trigger_q_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      step_r      <= step_s;
      delay_r     <= delay_s;
      lights_r    <= lights_s;
      start_r     <= start_s;
      busy_r      <= busy_s;
      fs_r        <= fs_s;
      trigger_q_r <= trigger;
    end
  end

  // Next-state and next-output logic; start_counting defaults low so it can
  // only ever be high for the single cycle after the final hold tick
  always_comb begin
    state_s  = state_r;
    step_s   = step_r;
    delay_s  = delay_r;
    lights_s = lights_r;
    start_s  = 1'b0;
    busy_s   = busy_r;
    fs_s     = fs_r;

    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (rise_s) begin
          // a tick arriving together with the trigger edge is not counted
          state_s  = SEQ;
          lights_s = 10'd0;
          step_s   = 16'd0;
          fs_s     = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      SEQ: begin
        if (response) begin
          state_s  = IDLE;
          lights_s = 10'd0;
          fs_s     = 1'b1;
          busy_s   = 1'b0;
        end else if (tick) begin
          if (step_r == STEP_LAST) begin
            lights_s = lights_shift_s;
            step_s   = 16'd0;
            if (lights_shift_s == ALL_LIT) begin
              state_s = HOLD;
              delay_s = MIN_HOLD + {9'd0, hold_rand_s};
            end else begin
              state_s = SEQ;
            end
          end else begin
            step_s = step_r + 16'd1;
          end
        end else begin
          state_s = SEQ;
        end
      end

      HOLD: begin
        // response takes priority over the final tick: no pulse on a tie
        if (response) begin
          state_s  = IDLE;
          lights_s = 10'd0;
          fs_s     = 1'b1;
          busy_s   = 1'b0;
        end else if (tick) begin
          if (delay_r == 16'd0) begin
            state_s  = IDLE;
            lights_s = 10'd0;
            start_s  = 1'b1;
            busy_s   = 1'b0;
          end else begin
            delay_s = delay_r - 16'd1;
          end
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s  = IDLE;
        lights_s = 10'd0;
        busy_s   = 1'b0;
      end
    endcase
  end

  assign lights         = lights_r;
  assign start_counting = start_r;
  assign busy           = busy_r;
  assign false_start    = fs_r;

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus with STEP_TICKS=2, MIN_DELAY=4 and
// tick tied high. Works with REACTION_STIM_FIXED_DELAY_EN defined (exact hold
// of MIN_DELAY+64 checked) or undefined (hold range and variety checked).
`timescale 1ns/1ps
module tb_reaction_stimulus;

  localparam int STEP = 2;
  localparam int MIND = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       trigger = 1'b0;
  logic       response = 1'b0;
  logic [9:0] lights;
  logic       start_counting;
  logic       busy;
  logic       false_start;

  int vectors = 0;
  int miscompares = 0;

  reaction_stimulus #(.STEP_TICKS(STEP), .MIN_DELAY(MIND)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .trigger        (trigger),
    .response       (response),
    .lights         (lights),
    .start_counting (start_counting),
    .busy           (busy),
    .false_start    (false_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       trig;
    logic       resp;
    logic [9:0] lights;
    logic       busy;
    logic       fs;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trigger  = 1'b0;
    response = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Starts a sequence from IDLE (trigger low beforehand). Edge n counts from
  // the trigger-rise edge. response is high only for the cycle sampled at
  // edge resp_at (0 = never). Stops once busy drops or the budget runs out.
  task automatic run_seq(input int resp_at, input bit check_ramp,
                         output int full_at, output int go_at, output int end_at);
    int ramp;
    full_at = -1;
    go_at   = -1;
    end_at  = -1;
    trigger = 1'b1;
    cyc();
    for (int n = 1; n <= 400; n++) begin
      response = (n == resp_at);
      cyc();
      if (lights == 10'h3FF && full_at < 0) full_at = n;
      if (check_ramp && busy) begin
        ramp = (1 << (n / 2)) - 1;
        if (n <= 20) chk("ramp_lights", lights, 32'(ramp));
        else         chk("hold_lights", lights, 32'h3FF);
        chk("early_start", start_counting, 0);
      end
      if (!busy) begin
        end_at = n;
        if (start_counting) go_at = n;
        break;
      end
    end
    response = 1'b0;
    trigger  = 1'b0;
    if (end_at < 0) chk("seq_timeout", 0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int full, go, fin, full2, go2, fin2, hold, first_hold, distinct, pulses;
    logic prev_start;

    //        trig  resp  lights   busy  fs
    tbl[0]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0};  // response in IDLE ignored
    tbl[4]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0};  // rise at T
    tbl[5]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'h001, 1'b1, 1'b0};  // T+2
    tbl[7]  = '{1'b1, 1'b0, 10'h001, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 10'h003, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 10'h007, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10'h007, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 10'h00F, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 10'h00F, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 10'h01F, 1'b1, 1'b0};  // rise while busy ignored
    tbl[15] = '{1'b1, 1'b1, 10'h000, 1'b0, 1'b1};  // false start
    tbl[16] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b1};  // sticky, response ignored
    tbl[19] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0};  // new rise clears flag
    tbl[20] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 10'h001, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b1};  // false start during SEQ
    tbl[23] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1};

    // reset values, then ten idle cycles with trigger low
    rst_n = 1'b0;
    #12;
    chk("rst_lights", lights, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_counting, 0);
    chk("rst_fs", false_start, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_start", start_counting, 0);
      chk("idle_busy", busy, 0);
      chk("idle_lights", lights, 0);
    end

    // table-driven vectors
    do_reset();
    for (int i = 0; i < 24; i++) begin
      trigger  = tbl[i].trig;
      response = tbl[i].resp;
      cyc();
      chk($sformatf("tbl%0d_lights", i), lights, 32'(tbl[i].lights));
      chk($sformatf("tbl%0d_busy", i), busy, 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_fs", i), false_start, 32'(tbl[i].fs));
      chk($sformatf("tbl%0d_start", i), start_counting, 0);
    end
    trigger  = 1'b0;
    response = 1'b0;

    // full sequence from a known point after reset
    do_reset();
    repeat (5) cyc();
    run_seq(0, 1'b1, full, go, fin);
    chk("full_at", full, 20);
    chk("go_lights", lights, 0);
    chk("go_start", start_counting, 1);
    chk("go_busy", busy, 0);
    chk("go_fs", false_start, 0);
    hold = go - full - 1;
`ifdef REACTION_STIM_FIXED_DELAY_EN
    chk("go_cycle", go, 20 + MIND + 64 + 1);
`else
    chk("go_hold_range", (hold >= MIND + 1 && hold <= MIND + 127), 1);
`endif
    cyc();
    chk("pulse_width", start_counting, 0);

    // identical replay with response on the final hold tick
    do_reset();
    repeat (5) cyc();
    run_seq(go, 1'b0, full2, go2, fin2);
    chk("tie_end", fin2, go);
    chk("tie_no_go", go2, -1);
    chk("tie_fs", false_start, 1);
    chk("tie_lights", lights, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pulses += start_counting;
    end
    chk("tie_no_late_pulse", pulses, 0);

    // trigger held high and toggled while busy: one pulse per IDLE rise
    do_reset();
    repeat (2) cyc();
    pulses = 0;
    prev_start = 1'b0;
    for (int n = 1; n <= 250; n++) begin
      trigger = !(n == 30 || n == 50);
      cyc();
      pulses += start_counting;
      chk("pulse_single_cycle", start_counting & prev_start, 0);
      prev_start = start_counting;
    end
    chk("held_pulses", pulses, 1);
    chk("held_no_rearm", busy, 0);
    trigger = 1'b0;
    cyc();
    for (int n = 1; n <= 250; n++) begin
      trigger = 1'b1;
      cyc();
      pulses += start_counting;
    end
    trigger = 1'b0;
    chk("second_rise_pulses", pulses, 2);

    // back-to-back sequences with varying spacing
    first_hold = -1;
    distinct = 0;
    for (int s = 0; s < 50; s++) begin
      repeat ((s % 7) + 1) cyc();
      run_seq(0, 1'b0, full, go, fin);
      hold = go - full - 1;
`ifdef REACTION_STIM_FIXED_DELAY_EN
      chk("hold_fixed", hold, MIND + 64);
`else
      chk("hold_range", (hold >= MIND + 1 && hold <= MIND + 127), 1);
`endif
      if (first_hold < 0) first_hold = hold;
      else if (hold != first_hold) distinct = 1;
    end
`ifdef REACTION_STIM_FIXED_DELAY_EN
    chk("hold_constant", distinct, 0);
`else
    chk("hold_distinct", distinct, 1);
`endif

    // asynchronous reset in the middle of HOLD
    cyc();
    trigger = 1'b1;
    cyc();
    repeat (23) cyc();
    chk("midhold_busy", busy, 1);
    chk("midhold_lights", lights, 32'h3FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lights", lights, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", start_counting, 0);
    repeat (2) begin
      cyc();
      chk("arst_hold_start", start_counting, 0);
    end
    trigger = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
